shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
Sequential unsigned multiplier and its controller, built around the ripple-carry adder chain from our full_adder cells. A start/done handshake launches one multiply. The FSM reuses a single WIDTH-bit adder for WIDTH add-and-shift steps. Compute blocks use it wherever a product is needed and area matters more than latency.

Parameters:
WIDTH, 4, operand width in bits; legal range is 2 to 16.

Ports:
clk  input  1  system clock; the only clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
start  input  1  request to begin a multiply; honoured only in IDLE.
a  input  WIDTH  multiplicand; sampled on the edge that accepts start.
b  input  WIDTH  multiplier; sampled on the edge that accepts start.
busy  output  1  high while in CALC or DONE.
done  output  1  one-cycle pulse; product is valid from this cycle onward.
product  output  2*WIDTH  result register; holds its value until the next completion or reset.

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes IDLE; busy=0, done=0, product=0.
  - Internal mcand, acc, mplier and cnt are cleared.
  - Reset has priority over all other inputs, including mid-CALC. Any partial result is discarded and product stays 0.
- All outputs are registered. No combinational path from any input to any output.
- Internal registers:
  - mcand: WIDTH bits.
  - acc: WIDTH bits, the high half of the partial product.
  - mplier: WIDTH bits, the low half, shifting.
  - cnt: clog2(WIDTH) bits.
- State IDLE:
  - busy=0.
  - If start=1 at an edge: mcand<=a, mplier<=b, acc<=0, cnt<=0, state<=CALC.
  - Otherwise all registers hold.
- State CALC, one step per edge:
  - Addend = mplier[0] ? mcand : 0.
  - {c,s} = acc + addend, formed by a chain of WIDTH full_adder instances with carry-in 0. No behavioural '+' on this datapath.
  - {acc,mplier} <= {c, s, mplier[WIDTH-1:1]}, i.e. the (2*WIDTH+1)-bit value shifted right by one.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 on this edge: state<=DONE, and product<={c, s, mplier[WIDTH-1:1]} (the final shifted value).
  - start is ignored.
- State DONE:
  - done=1 and busy=1 for exactly one cycle; then state<=IDLE.
  - start is ignored in DONE.
- Latency:
  - Edge E accepts start.
  - Edges E+1 through E+WIDTH perform the steps.
  - done is high in the cycle after edge E+WIDTH.
  - The earliest next start is accepted at edge E+WIDTH+2, i.e. a start held high from E+WIDTH+1 onward is accepted there.
  - Throughput: one multiply per WIDTH+2 cycles.
- Width rules:
  - The product never overflows: max is (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - The carry c is always absorbed into acc by the shift; no bits are lost.
- Holding and sampling:
  - a and b may change freely after the accepting edge; the result is unaffected.
  - start held continuously yields back-to-back multiplies, with IDLE occupying 1 cycle between them.
  - X on start while not in IDLE has no effect.

Test Plan:
1. WIDTH=4, reset, then a=3, b=5, start pulse at edge E -> done=1 exactly in the cycle after edge E+4; product=15; busy high from E+1 through the done cycle.
2. a=15, b=15 -> product=225 (8'hE1). Then a=0, b=9 -> product=0. Then a=9, b=0 -> product=0. product must hold 225 until the next done.
3. Start asserted while busy (cycles E+1..E+4) with different a/b -> ignored; first result (3x5=15) unchanged; no extra done pulse.
4. rst=1 at edge E+2 of an active multiply -> next cycle busy=0, done=0, product=0, state IDLE. A fresh 7x6 then completes normally with product=42.
5. start held high continuously with a=2, b=3 -> done pulses every 6 cycles; product=6 each time.
6. WIDTH=8 instance, a=200, b=250 -> product=50000 (16'hC350); done in the cycle after edge E+8.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mult_ctrl
//   Sequential unsigned WIDTH x WIDTH multiplier with its controlling FSM.
//   A single WIDTH-bit ripple-carry adder built from full_adder cells is reused
//   for WIDTH add-and-shift steps, so area stays small at the cost of latency.
//
// Ports
//   clk      : system clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : request a multiply, honoured only while idle
//   a, b     : multiplicand / multiplier, captured on the accepting edge
//   busy     : high while a multiply is in progress or signalling done
//   done     : one-cycle pulse when product has been updated
//   product  : 2*WIDTH-bit result, held until the next completion or reset
// -----------------------------------------------------------------------------

// Single-bit full adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic [2*WIDTH-1:0] shifted;
  logic               last_step;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend   = mplier[0] ? mcand : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder u_fa (
      .a  (acc[i]),
      .b  (addend[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // The carry-out becomes the new MSB of acc, so nothing is lost in the shift;
  // the multiplier LSB just consumed falls off the bottom.
  assign shifted   = {carry[WIDTH], sum, mplier[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start == 1'b1) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so outputs never see inputs
  // combinationally yet still line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start == 1'b1) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= shifted[2*WIDTH-1:WIDTH];
          mplier <= shifted[WIDTH-1:0];
          cnt    <= cnt + 1'b1;
          if (last_step) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult_ctrl
//   Scoreboard bench for shift_add_mult_ctrl at WIDTH=4 and WIDTH=8. Drivers
//   push {a*b, expected done cycle} into per-instance queues; independent
//   monitors pop and compare whenever done is seen, and check product holds.
// -----------------------------------------------------------------------------
module tb_shift_add_mult_ctrl;

  typedef struct {
    longint prod;
    int     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst4, rst8;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   q4[$];
  exp_t   q8[$];
  longint last4 = 0;
  longint last8 = 0;

  shift_add_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor for the WIDTH=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst4) begin
      if (done4) begin
        chk("done4_expected", longint'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("prod4", longint'(prod4), e.prod);
          chk("done4_cycle", longint'(cyc), longint'(e.cyc));
          last4 = e.prod;
        end
      end else begin
        chk("hold4", longint'(prod4), last4);
        if (q4.size() > 0 && cyc >= q4[0].cyc) begin
          chk("done4_missing", longint'(done4), 1);
          e = q4.pop_front();
        end
      end
    end
  end

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst8) begin
      if (done8) begin
        chk("done8_expected", longint'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("prod8", longint'(prod8), e.prod);
          chk("done8_cycle", longint'(cyc), longint'(e.cyc));
          last8 = e.prod;
        end
      end else begin
        chk("hold8", longint'(prod8), last8);
        if (q8.size() > 0 && cyc >= q8[0].cyc) begin
          chk("done8_missing", longint'(done8), 1);
          e = q8.pop_front();
        end
      end
    end
  end

  // One multiply on the 4-bit instance; optionally keeps start high (with
  // scrambled operands) while busy to show it is ignored.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit hold);
    int e;
    a4 = a; b4 = b; start4 = 1'b1;
    step();
    e = cyc;
    q4.push_back('{longint'(a) * longint'(b), e + 4});
    for (int i = 0; i <= 4; i++) begin
      chk("busy4_active", longint'(busy4), 1);
      start4 = hold;
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      step();
    end
    chk("busy4_idle", longint'(busy4), 0);
    start4 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int e;
    a8 = a; b8 = b; start8 = 1'b1;
    step();
    e = cyc;
    q8.push_back('{longint'(a) * longint'(b), e + 8});
    start8 = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      chk("busy8_active", longint'(busy8), 1);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      step();
    end
    chk("busy8_idle", longint'(busy8), 0);
  endtask

  initial begin
    int e0;
    rst4 = 1'b1; rst8 = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) step();
    chk("rst_busy4", longint'(busy4), 0);
    chk("rst_done4", longint'(done4), 0);
    chk("rst_prod4", longint'(prod4), 0);
    chk("rst_busy8", longint'(busy8), 0);
    chk("rst_done8", longint'(done8), 0);
    chk("rst_prod8", longint'(prod8), 0);
    rst4 = 1'b0; rst8 = 1'b0;
    step();

    run4(4'd3, 4'd5, 1'b0);
    run4(4'd15, 4'd15, 1'b0);
    repeat (3) step();
    run4(4'd0, 4'd9, 1'b0);
    run4(4'd9, 4'd0, 1'b0);
    run4(4'd3, 4'd5, 1'b1);

    // Abort a multiply with reset landing two edges after acceptance.
    a4 = 4'd11; b4 = 4'd13; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    rst4 = 1'b1;
    q4.delete();
    step();
    chk("abort_busy4", longint'(busy4), 0);
    chk("abort_done4", longint'(done4), 0);
    chk("abort_prod4", longint'(prod4), 0);
    last4 = 0;
    rst4 = 1'b0;
    repeat (2) step();
    run4(4'd7, 4'd6, 1'b0);

    // start held high: accepts every WIDTH+2 cycles.
    a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    step();
    e0 = cyc;
    for (int k = 0; k < 4; k++) q4.push_back('{6, e0 + k * 6 + 4});
    while (cyc < e0 + 22) step();
    start4 = 1'b0;
    repeat (3) step();
    chk("held_busy4_idle", longint'(busy4), 0);

    run8(8'd200, 8'd250);
    run8(8'd255, 8'd255);
    for (int n = 0; n < 12; n++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom));
      run8(8'($urandom), 8'($urandom));
    end

    repeat (4) step();
    chk("q4_drained", longint'(q4.size()), 0);
    chk("q8_drained", longint'(q8.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
